seg_scan_driver: RTL

Parametrised time-multiplexed seven-segment display driver for board-level debug output. It scans N_DIGITS common-anode digits at a prescaled rate and decodes one 4-bit hex nibble per digit. Per-digit decimal points, per-digit blanking, leading-zero suppression and an anti-ghosting dead time are included. It sits between the CPU's display register (e.g. PC or register-file tap) and the board's anode and segment pins.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-high glyphs,
// the dark segment pattern and a clog2 helper that never returns zero.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Index 15 is the leftmost element; bit order is {g,f,e,d,c,b,a}.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high seven-segment glyph, purely combinational.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display scanner with dead time, blanking,
// leading-zero suppression and output polarity selection.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 50000,
    parameter int BLANK_CYC      = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  lz_suppress,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int   CW      = clog2_min1(DIV);
    localparam int   IW      = clog2_min1(N_DIGITS);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_out_q, dp_out_d;
    logic                frame_tick_q, frame_tick_d;

    logic [N_DIGITS-1:0] lz_s;
    logic [3:0]          nib_s;
    logic                dp_sel_s, mask_sel_s, lz_sel_s, dead_s, lit_s;
    logic [6:0]          glyph_s;
    logic [N_DIGITS-1:0] an_hi_s;
    logic                run_s;

    // Prescaler and digit index advance; frame_tick marks the wrap back to digit 0.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        if (en) begin
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d = '0;
                if (idx_q == IW'(N_DIGITS - 1)) begin
                    idx_d        = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
            idx_d = idx_q;
        end
    end

    // A digit is suppressed while it and everything to its left is a plain zero.
    always_comb begin
        run_s = 1'b1;
        lz_s  = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            run_s   = run_s & (data[4*(N_DIGITS-1-i) +: 4] == 4'h0) & ~dp[N_DIGITS-1-i];
            lz_s[i] = lz_suppress & run_s & (i != N_DIGITS - 1);
        end
    end

    // Select the per-digit attributes of the digit about to be shown.
    always_comb begin
        nib_s      = 4'h0;
        dp_sel_s   = 1'b0;
        mask_sel_s = 1'b0;
        lz_sel_s   = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            nib_s      = nib_s | ((idx_d == IW'(i)) ? data[4*(N_DIGITS-1-i) +: 4] : 4'h0);
            dp_sel_s   = dp_sel_s | ((idx_d == IW'(i)) & dp[N_DIGITS-1-i]);
            mask_sel_s = mask_sel_s | ((idx_d == IW'(i)) & blank_mask[N_DIGITS-1-i]);
            lz_sel_s   = lz_sel_s | ((idx_d == IW'(i)) & lz_s[i]);
        end
    end

    seg7_decode u_decode (
        .nibble (nib_s),
        .seg    (glyph_s)
    );

    generate
        if (BLANK_CYC == 0) begin : g_no_dead
            assign dead_s = 1'b0;
        end else begin : g_dead
            assign dead_s = (cnt_d < CW'(BLANK_CYC));
        end
    endgenerate

    // Active-high output image followed by the polarity XOR stage.
    always_comb begin
        lit_s   = en & ~dead_s & ~mask_sel_s & ~lz_sel_s;
        an_hi_s = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_hi_s[N_DIGITS-1-i] = lit_s & (idx_d == IW'(i));
        end
        an_d     = an_hi_s ^ {N_DIGITS{AN_INV}};
        seg_d    = (lit_s ? glyph_s : SEG_OFF) ^ {7{SEG_INV}};
        dp_out_d = (lit_s & dp_sel_s) ^ SEG_INV;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            an_q         <= {N_DIGITS{AN_INV}};
            seg_q        <= SEG_OFF ^ {7{SEG_INV}};
            dp_out_q     <= SEG_INV;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign frame_tick = frame_tick_q;

endmodule
